// File: rtl/vga_colour_cycle.sv
// Pixel-clock front end: VGA sync/timing generator plus a timed 8-colour sequencer.
// Ports:
//   clk    - pixel clock; all state changes on its rising edge
//   rst    - synchronous active-high reset
//   hsync  - horizontal sync, active low (decoded from col)
//   vsync  - vertical sync, active low (decoded from row)
//   vid_on - high while (col,row) lies in the visible area
//   row    - current line, 0..VLIM-1
//   col    - current column, 0..HLIM-1
//   red/green/blue - 4-bit channels of the current colour (not gated by vid_on)
module vga_colour_cycle #(
  parameter int unsigned HDISP         = 640,
  parameter int unsigned HFP           = 16,
  parameter int unsigned HPW           = 96,
  parameter int unsigned HLIM          = 800,
  parameter int unsigned VDISP         = 480,
  parameter int unsigned VFP           = 10,
  parameter int unsigned VPW           = 2,
  parameter int unsigned VLIM          = 525,
  parameter int unsigned COUNTER_WIDTH = 25,
  parameter int unsigned COUNT_FROM    = 0,
  parameter int unsigned COUNT_TO      = 24_999_999,
  parameter int unsigned COUNT_RESET   = 0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        hsync,
  output logic        vsync,
  output logic        vid_on,
  output logic [10:0] row,
  output logic [10:0] col,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  localparam int unsigned POS_W = 11;
  localparam int unsigned RGB_W = 12;

  localparam logic [POS_W-1:0] COL_LAST = POS_W'(HLIM - 1);
  localparam logic [POS_W-1:0] ROW_LAST = POS_W'(VLIM - 1);
  localparam logic [POS_W-1:0] HS_START = POS_W'(HDISP + HFP);
  localparam logic [POS_W-1:0] HS_END   = POS_W'(HDISP + HFP + HPW);
  localparam logic [POS_W-1:0] VS_START = POS_W'(VDISP + VFP);
  localparam logic [POS_W-1:0] VS_END   = POS_W'(VDISP + VFP + VPW);
  localparam logic [POS_W-1:0] H_VIS    = POS_W'(HDISP);
  localparam logic [POS_W-1:0] V_VIS    = POS_W'(VDISP);

  localparam logic [COUNTER_WIDTH-1:0] CNT_FROM  = COUNTER_WIDTH'(COUNT_FROM);
  localparam logic [COUNTER_WIDTH-1:0] CNT_TO    = COUNTER_WIDTH'(COUNT_TO);
  localparam logic [COUNTER_WIDTH-1:0] CNT_RESET = COUNTER_WIDTH'(COUNT_RESET);

  typedef enum logic [2:0] {
    C_RED, C_YELLOW, C_GREEN, C_CYAN, C_BLUE, C_MAGENTA, C_WHITE, C_BLACK
  } colour_t;

  logic [POS_W-1:0]         col_q, row_q;
  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic                     step;
  colour_t                  state_q, state_nxt;
  logic [RGB_W-1:0]         rgb_q, rgb_nxt;

  // Line/frame position counters; row advances on the column wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (col_q == COL_LAST) begin
      col_q <= '0;
      row_q <= (row_q == ROW_LAST) ? '0 : row_q + POS_W'(1);
    end else begin
      col_q <= col_q + POS_W'(1);
    end
  end

  // Zero-latency sync and visible-area decodes.
  assign hsync  = !((col_q >= HS_START) && (col_q < HS_END));
  assign vsync  = !((row_q >= VS_START) && (row_q < VS_END));
  assign vid_on = (col_q < H_VIS) && (row_q < V_VIS);
  assign row    = row_q;
  assign col    = col_q;

  // Prescaler; >= catches a reset value at or beyond the terminal count.
  assign step = (cnt_q >= CNT_TO);

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= CNT_RESET;
    else     cnt_q <= step ? CNT_FROM : cnt_q + COUNTER_WIDTH'(1);
  end

  // Colour state and its registered RGB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= C_RED;
      rgb_q   <= 12'hF00;
    end else begin
      state_q <= state_nxt;
      rgb_q   <= rgb_nxt;
    end
  end

  // Next colour on each step; RGB follows the next state so it is registered with it.
  always_comb begin
    state_nxt = state_q;
    rgb_nxt   = 12'hF00;
    if (step) begin
      unique case (state_q)
        C_RED:     state_nxt = C_YELLOW;
        C_YELLOW:  state_nxt = C_GREEN;
        C_GREEN:   state_nxt = C_CYAN;
        C_CYAN:    state_nxt = C_BLUE;
        C_BLUE:    state_nxt = C_MAGENTA;
        C_MAGENTA: state_nxt = C_WHITE;
        C_WHITE:   state_nxt = C_BLACK;
        C_BLACK:   state_nxt = C_RED;
        default:   state_nxt = C_RED;
      endcase
    end
    unique case (state_nxt)
      C_RED:     rgb_nxt = 12'hF00;
      C_YELLOW:  rgb_nxt = 12'hFF0;
      C_GREEN:   rgb_nxt = 12'h0F0;
      C_CYAN:    rgb_nxt = 12'h0FF;
      C_BLUE:    rgb_nxt = 12'h00F;
      C_MAGENTA: rgb_nxt = 12'hF0F;
      C_WHITE:   rgb_nxt = 12'hFFF;
      C_BLACK:   rgb_nxt = 12'h000;
      default:   rgb_nxt = 12'hF00;
    endcase
  end

  assign red   = rgb_q[11:8];
  assign green = rgb_q[7:4];
  assign blue  = rgb_q[3:0];

endmodule

// File: tb/tb_vga_colour_cycle.sv
// Self-checking bench for vga_colour_cycle using a tiny 10x6 raster and a 4-clock colour step.
module tb_vga_colour_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsync, vsync, vid_on;
  logic [10:0] row, col;
  logic [3:0]  red, green, blue;

  int n_checks = 0;
  int n_errors = 0;

  vga_colour_cycle #(
    .HDISP(6), .HFP(1), .HPW(1), .HLIM(10),
    .VDISP(2), .VFP(1), .VPW(1), .VLIM(6),
    .COUNTER_WIDTH(3), .COUNT_FROM(0), .COUNT_TO(3), .COUNT_RESET(3)
  ) dut (
    .clk(clk), .rst(rst),
    .hsync(hsync), .vsync(vsync), .vid_on(vid_on),
    .row(row), .col(col),
    .red(red), .green(green), .blue(blue)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Colour loop: index 0 = RED ... 7 = BLACK.
  function automatic logic [11:0] colour_of(input int idx);
    case (idx % 8)
      0: return 12'hF00;
      1: return 12'hFF0;
      2: return 12'h0F0;
      3: return 12'h0FF;
      4: return 12'h00F;
      5: return 12'hF0F;
      6: return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  task automatic check_reset_state();
    check("rst_col", 32'(col), 32'd0);
    check("rst_row", 32'(row), 32'd0);
    check("rst_hsync", 32'(hsync), 32'd1);
    check("rst_vsync", 32'(vsync), 32'd1);
    check("rst_vid_on", 32'(vid_on), 32'd1);
    check("rst_rgb", 32'({red, green, blue}), 32'h0F00);
  endtask

  // k = clock edges since reset released; checks every output against the hand model.
  task automatic check_cycle(input int k);
    int ec, er;
    ec = k % 10;
    er = (k / 10) % 6;
    check("col", 32'(col), 32'(ec));
    check("row", 32'(row), 32'(er));
    check("hsync", 32'(hsync), 32'(ec != 7));
    check("vsync", 32'(vsync), 32'(er != 3));
    check("vid_on", 32'(vid_on), 32'((ec < 6) && (er < 2)));
    check("rgb", 32'({red, green, blue}), 32'(colour_of((k - 1) / 4 + 1)));
  endtask

  initial begin
    int vis_cnt;
    int hs_low;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    vis_cnt = 0;
    hs_low  = 0;
    for (int k = 1; k <= 204; k++) begin
      @(posedge clk);
      #1;
      check_cycle(k);
      if (k <= 60) begin
        vis_cnt += int'(vid_on);
        hs_low  += int'(!hsync);
      end
    end
    // Frame totals over edges 1..60 (one full frame): 12 visible clocks, one hsync per line.
    check("vis_per_frame", 32'(vis_cnt), 32'd12);
    check("hsync_lows", 32'(hs_low), 32'd6);

    // Mid-frame reset point: row 2, col 4, colour CYAN.
    check("pre_rst_col", 32'(col), 32'd4);
    check("pre_rst_row", 32'(row), 32'd2);
    check("pre_rst_rgb", 32'({red, green, blue}), 32'h00FF);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      check_cycle(k);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
